booth_mult_sequencer: RTL

//  Issue/collect front end for the sequential radix-4 Booth multiplier core.
//  - Accepts signed operand pairs with a tag over a valid/ready input stream.
//  - Drives the core's operand, enable and core-reset pins, then waits for the core's done pulse.
//  - Captures the 64-bit product and returns it with its tag over a valid/ready output stream.
//  - Product returns pass through a small result FIFO.
//  - Sits between the operand producer and the result consumer; the core sits beside it.

---
 rtl/booth_seq_pkg.sv | 30 +++
 rtl/booth_result_fifo.sv | 63 ++++++
 rtl/booth_mult_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/booth_seq_pkg.sv
// Shared definitions for the Booth multiplier issue/collect sequencer:
// FSM encoding and the layout of a result FIFO entry {err, tag, product}.
package booth_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } seq_state_e;

  localparam int DATA_W_DEF  = 32;
  localparam int TAG_W_DEF   = 4;
  localparam int ENTRY_W_DEF = 2 * DATA_W_DEF + TAG_W_DEF + 1;

  // Entry layout, LSB first: product [2*DW-1:0], tag, then the error flag on top.
  localparam int RES_LSB = 0;

  function automatic int entry_w(input int data_w, input int tag_w);
    return 2 * data_w + tag_w + 1;
  endfunction

  function automatic int tag_lsb(input int data_w);
    return 2 * data_w;
  endfunction

  function automatic int err_bit(input int data_w, input int tag_w);
    return 2 * data_w + tag_w;
  endfunction

endpackage

// File: rtl/booth_result_fifo.sv
// First-word-fall-through result FIFO: head is visible on rdata_o whenever
// empty_o is low. Pointers wrap naturally; occupancy is kept in its own counter.
module booth_result_fifo #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is still safe when the head leaves on the same edge.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/booth_mult_sequencer.sv
// Issue/collect front end for the sequential radix-4 Booth core: accepts tagged
// operand pairs, runs one operation at a time, and queues tagged products.
module booth_mult_sequencer
  import booth_seq_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 4,
  parameter int RES_DEPTH = 2,
  parameter int TIMEOUT   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [DATA_W-1:0]   in_a_i,
  input  logic [DATA_W-1:0]   in_b_i,
  input  logic [TAG_W-1:0]    in_tag_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [2*DATA_W-1:0] out_result_o,
  output logic [TAG_W-1:0]    out_tag_o,
  output logic                out_err_o,
  output logic [DATA_W-1:0]   core_a_o,
  output logic [DATA_W-1:0]   core_b_o,
  output logic                core_en_o,
  output logic                core_reset_o,
  input  logic [2*DATA_W-1:0] core_result_i,
  input  logic                core_done_i,
  output logic                busy_o
);

  localparam int EW      = entry_w(DATA_W, TAG_W);
  localparam int TAG_LSB = tag_lsb(DATA_W);
  localparam int ERR_BIT = err_bit(DATA_W, TAG_W);
  localparam int AW      = $clog2(RES_DEPTH);
  localparam int CW      = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(RES_DEPTH);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  seq_state_e          state_q;
  logic                armed_q;
  logic [DATA_W-1:0]   op_a_q;
  logic [DATA_W-1:0]   op_b_q;
  logic [TAG_W-1:0]    op_tag_q;
  logic                core_en_q;
  logic                core_rst_q;
  logic [CW-1:0]       wait_q;

  logic                accept;
  logic                run_end;
  logic                timed_out;
  logic                fifo_push;
  logic                fifo_pop;
  logic [EW-1:0]       push_data;
  logic [EW-1:0]       head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [AW:0]         fifo_count;

  // armed_q keeps in_ready low while reset is held, even though state is IDLE.
  assign in_ready_o = armed_q && (state_q == ST_IDLE) && (fifo_count < DEPTH_C);
  assign accept     = in_valid_i && in_ready_o;
  assign timed_out  = (wait_q == WAIT_LAST);
  assign run_end    = (state_q == ST_RUN) && (core_done_i || timed_out);

  assign push_data = core_done_i ? {1'b0, op_tag_q, core_result_i}
                                 : {1'b1, op_tag_q, {(2 * DATA_W){1'b0}}};
  assign fifo_push = run_end && !fifo_full;
  assign fifo_pop  = out_valid_o && out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      armed_q    <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_tag_q   <= '0;
      core_en_q  <= 1'b0;
      core_rst_q <= 1'b0;
      wait_q     <= '0;
    end else begin
      armed_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_a_q     <= in_a_i;
            op_b_q     <= in_b_i;
            op_tag_q   <= in_tag_i;
            core_en_q  <= 1'b1;
            core_rst_q <= 1'b1;
            state_q    <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          core_rst_q <= 1'b0;
          wait_q     <= '0;
          state_q    <= ST_RUN;
        end
        ST_RUN: begin
          if (run_end) begin
            core_en_q <= 1'b0;
            state_q   <= ST_IDLE;
          end else begin
            wait_q <= wait_q + CW'(1);
          end
        end
        default: begin
          core_en_q  <= 1'b0;
          core_rst_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  booth_result_fifo #(
    .WIDTH (EW),
    .DEPTH (RES_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (push_data),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Stale FIFO storage is masked so the output bus reads 0 whenever nothing is offered.
  assign out_valid_o  = !fifo_empty;
  assign out_result_o = out_valid_o ? head[RES_LSB +: 2*DATA_W] : '0;
  assign out_tag_o    = out_valid_o ? head[TAG_LSB +: TAG_W] : '0;
  assign out_err_o    = out_valid_o && head[ERR_BIT];

  assign core_a_o     = op_a_q;
  assign core_b_o     = op_b_q;
  assign core_en_o    = core_en_q;
  assign core_reset_o = core_rst_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule
